// File: rtl/iir_pkg.sv
// ----------------------------------------------------------------------------
// iir_pkg
// Shared definitions for the multi-channel biquad section:
//   - FSM state encoding
//   - coefficient select codes (cfg_sel)
//   - power-on coefficient set applied to every channel
//   - output saturate / wrap helpers
// ----------------------------------------------------------------------------
package iir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAC0 = 3'd1,
        ST_MAC1 = 3'd2,
        ST_MAC2 = 3'd3,
        ST_MAC3 = 3'd4,
        ST_MAC4 = 3'd5,
        ST_RES  = 3'd6,
        ST_OUT  = 3'd7
    } iir_state_e;

    localparam logic [2:0] SEL_B0 = 3'd0;
    localparam logic [2:0] SEL_B1 = 3'd1;
    localparam logic [2:0] SEL_B2 = 3'd2;
    localparam logic [2:0] SEL_A1 = 3'd3;
    localparam logic [2:0] SEL_A2 = 3'd4;

    localparam int NTAP = 5;

    // Order matches the tap order b0, b1, b2, a1, a2.
    localparam int COEF_DEF [NTAP] = '{30, 40, 30, 707, -212};

    // Clamp v to a signed dw-bit range when sat_en is set, otherwise pass it
    // through (the caller keeps only the low dw bits, i.e. wraps).
    function automatic logic signed [63:0] sat_or_wrap(input logic signed [63:0] v,
                                                       input int              dw,
                                                       input logic            sat_en);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (sat_en && (v > hi)) begin
            r = hi;
        end else if (sat_en && (v < lo)) begin
            r = lo;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // 1 when sat_or_wrap would clip v.
    function automatic logic sat_hit(input logic signed [63:0] v,
                                     input int              dw,
                                     input logic            sat_en);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        return sat_en && ((v > hi) || (v < lo));
    endfunction

endpackage

// File: rtl/iir_mac_unit.sv
// ----------------------------------------------------------------------------
// iir_mac_unit
// Registered signed multiplier feeding an ACCW-bit accumulator.
//   clk, rst  : clock, synchronous active-low reset
//   clr       : clear accumulator and product register on the next edge
//   en        : register a*b on the next edge (otherwise the product reg is 0)
//   a, b      : signed operands
//   acc       : accumulator including the pending product (acc_q + prod_q),
//               so the last tap is visible one cycle after it is presented
// ----------------------------------------------------------------------------
module iir_mac_unit #(
    parameter int AW   = 12,
    parameter int BW   = 12,
    parameter int ACCW = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic signed [AW-1:0]   a,
    input  logic signed [BW-1:0]   b,
    output logic signed [ACCW-1:0] acc
);

    logic signed [AW+BW-1:0] prod_q;
    logic signed [AW+BW-1:0] prod_d;
    logic signed [ACCW-1:0]  acc_q;
    logic signed [ACCW-1:0]  acc_d;

    // Next product and accumulator values.
    always_comb begin
        prod_d = '0;
        acc_d  = acc_q;
        if (en) begin
            prod_d = a * b;
        end else begin
            prod_d = '0;
        end
        if (clr) begin
            acc_d  = '0;
            prod_d = '0;
        end else begin
            acc_d = acc_q + ACCW'(prod_q);
        end
    end

    // Product and accumulator registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

    assign acc = acc_q + ACCW'(prod_q);

endmodule

// File: rtl/iir_biquad_mc.sv
// ----------------------------------------------------------------------------
// iir_biquad_mc
// Time-multiplexed multi-channel biquad: y = b0*x + b1*x1 + b2*x2 + a1*y1 + a2*y2,
// scaled by >>> SHIFT and saturated (SAT_EN=1) or wrapped to DW_OUT bits.
// One shared MAC evaluates the five taps in MAC0..MAC4; history and
// coefficients are held per channel.
//   clk, rst                : clock, synchronous active-low reset
//   in_valid/in_ready       : input handshake; in_ch / in_data sample
//   out_valid/out_ready     : output handshake; out_ch / out_data / out_sat
//   cfg_we/cfg_ch/cfg_sel/  : coefficient write (sel 0..4 = b0,b1,b2,a1,a2)
//   cfg_data
// ----------------------------------------------------------------------------
module iir_biquad_mc
    import iir_pkg::*;
#(
    parameter  int NCH    = 4,
    parameter  int DW_IN  = 12,
    parameter  int DW_OUT = 8,
    parameter  int CW     = 12,
    parameter  int ACCW   = 32,
    parameter  int SHIFT  = 11,
    parameter  int SAT_EN = 1,
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHW-1:0]           in_ch,
    input  logic signed [DW_IN-1:0]  in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CHW-1:0]           out_ch,
    output logic signed [DW_OUT-1:0] out_data,
    output logic                     out_sat,
    input  logic                     cfg_we,
    input  logic [CHW-1:0]           cfg_ch,
    input  logic [2:0]               cfg_sel,
    input  logic signed [CW-1:0]     cfg_data
);

    localparam int             OPW   = (DW_IN > DW_OUT) ? DW_IN : DW_OUT;
    localparam logic [CHW:0]   NCH_L = (CHW + 1)'(NCH);

    iir_state_e               state_q, state_d;
    logic signed [DW_IN-1:0]  x_q, x_d;
    logic [CHW-1:0]           ch_q, ch_d;
    logic                     bad_q, bad_d;
    logic signed [CW-1:0]     w_q [NTAP];
    logic signed [CW-1:0]     w_d [NTAP];
    logic signed [CW-1:0]     coef_q [NCH][NTAP];
    logic signed [CW-1:0]     coef_d [NCH][NTAP];
    logic signed [DW_IN-1:0]  x1_q [NCH];
    logic signed [DW_IN-1:0]  x1_d [NCH];
    logic signed [DW_IN-1:0]  x2_q [NCH];
    logic signed [DW_IN-1:0]  x2_d [NCH];
    logic signed [DW_OUT-1:0] y1_q [NCH];
    logic signed [DW_OUT-1:0] y1_d [NCH];
    logic signed [DW_OUT-1:0] y2_q [NCH];
    logic signed [DW_OUT-1:0] y2_d [NCH];
    logic                     out_valid_q, out_valid_d;
    logic signed [DW_OUT-1:0] out_data_q, out_data_d;
    logic [CHW-1:0]           out_ch_q, out_ch_d;
    logic                     out_sat_q, out_sat_d;

    logic                     mac_clr_s;
    logic                     mac_en_s;
    logic signed [OPW-1:0]    op_a_s;
    logic signed [CW-1:0]     op_b_s;
    logic signed [ACCW-1:0]   acc_s;
    logic signed [ACCW-1:0]   acc_sh_s;
    logic signed [63:0]       acc_ext_s;
    logic signed [DW_OUT-1:0] y_s;
    logic                     y_sat_s;
    logic                     in_ch_ok_s;
    logic                     cfg_ok_s;

    iir_mac_unit #(
        .AW   (OPW),
        .BW   (CW),
        .ACCW (ACCW)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr_s),
        .en  (mac_en_s),
        .a   (op_a_s),
        .b   (op_b_s),
        .acc (acc_s)
    );

    assign in_ch_ok_s = ({1'b0, in_ch} < NCH_L);
    assign cfg_ok_s   = ({1'b0, cfg_ch} < NCH_L) && (cfg_sel <= SEL_A2);
    assign acc_sh_s   = acc_s >>> SHIFT;
    assign acc_ext_s  = 64'(acc_sh_s);
    assign y_s        = DW_OUT'(sat_or_wrap(acc_ext_s, DW_OUT, SAT_EN != 0));
    assign y_sat_s    = sat_hit(acc_ext_s, DW_OUT, SAT_EN != 0);

    // Next-state, tap operand selection and history / coefficient updates.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        ch_d        = ch_q;
        bad_d       = bad_q;
        w_d         = w_q;
        coef_d      = coef_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_sat_d   = out_sat_q;
        mac_clr_s   = 1'b0;
        mac_en_s    = 1'b0;
        op_a_s      = '0;
        op_b_s      = '0;

        // The bank is written in any state; the working set w_q shields an
        // in-flight sample from the change.
        if (cfg_we && cfg_ok_s) begin
            coef_d[cfg_ch][cfg_sel] = cfg_data;
        end else begin
            coef_d = coef_q;
        end

        case (state_q)
            ST_IDLE: begin
                mac_clr_s = 1'b1;
                if (in_valid) begin
                    x_d     = in_data;
                    ch_d    = in_ch;
                    bad_d   = !in_ch_ok_s;
                    state_d = ST_MAC0;
                    for (int k = 0; k < NTAP; k++) begin
                        w_d[k] = in_ch_ok_s ? coef_q[in_ch][k] : '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC0: begin
                // An out-of-range channel is swallowed: no taps, no output.
                if (bad_q) begin
                    state_d = ST_IDLE;
                end else begin
                    mac_en_s = 1'b1;
                    op_a_s   = OPW'(x_q);
                    op_b_s   = w_q[0];
                    state_d  = ST_MAC1;
                end
            end
            ST_MAC1: begin
                mac_en_s = 1'b1;
                op_a_s   = OPW'(x1_q[ch_q]);
                op_b_s   = w_q[1];
                state_d  = ST_MAC2;
            end
            ST_MAC2: begin
                mac_en_s = 1'b1;
                op_a_s   = OPW'(x2_q[ch_q]);
                op_b_s   = w_q[2];
                state_d  = ST_MAC3;
            end
            ST_MAC3: begin
                mac_en_s = 1'b1;
                op_a_s   = OPW'(y1_q[ch_q]);
                op_b_s   = w_q[3];
                state_d  = ST_MAC4;
            end
            ST_MAC4: begin
                mac_en_s = 1'b1;
                op_a_s   = OPW'(y2_q[ch_q]);
                op_b_s   = w_q[4];
                state_d  = ST_RES;
            end
            ST_RES: begin
                out_valid_d  = 1'b1;
                out_data_d   = y_s;
                out_ch_d     = ch_q;
                out_sat_d    = y_sat_s;
                x2_d[ch_q]   = x1_q[ch_q];
                x1_d[ch_q]   = x_q;
                y2_d[ch_q]   = y1_q[ch_q];
                y1_d[ch_q]   = y_s;
                state_d      = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, working set, history, coefficient bank and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            ch_q        <= '0;
            bad_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_sat_q   <= 1'b0;
            for (int k = 0; k < NTAP; k++) begin
                w_q[k] <= '0;
            end
            for (int c = 0; c < NCH; c++) begin
                x1_q[c] <= '0;
                x2_q[c] <= '0;
                y1_q[c] <= '0;
                y2_q[c] <= '0;
                for (int k = 0; k < NTAP; k++) begin
                    coef_q[c][k] <= CW'(COEF_DEF[k]);
                end
            end
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            ch_q        <= ch_d;
            bad_q       <= bad_d;
            w_q         <= w_d;
            coef_q      <= coef_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = rst && (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_iir_biquad_mc.sv
// ----------------------------------------------------------------------------
// tb_iir_biquad_mc
// Directed scenarios plus randomized samples / coefficient writes, checked
// against a transaction-level model of the biquad (integer arithmetic with
// floor division and clamping). DUT built with NCH=3 so channel 3 is invalid.
// ----------------------------------------------------------------------------
module tb_iir_biquad_mc;

    localparam int NCH = 3;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ch;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
    logic [7:0]  out_data;
    logic        out_sat;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [2:0]  cfg_sel;
    logic [11:0] cfg_data;

    int checks;
    int failures;

    // reference model state
    int mc  [NCH][5];
    int mx1 [NCH];
    int mx2 [NCH];
    int my1 [NCH];
    int my2 [NCH];

    iir_biquad_mc #(
        .NCH    (NCH),
        .DW_IN  (12),
        .DW_OUT (8),
        .CW     (12),
        .ACCW   (32),
        .SHIFT  (11),
        .SAT_EN (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint d);
        longint q;
        q = a / d;
        if (((a % d) != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic void model_reset();
        int def [5];
        def = '{30, 40, 30, 707, -212};
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < 5; k++) mc[c][k] = def[k];
            mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0;
        end
    endfunction

    // y[n] for channel ch with the current bank and history (no commit).
    function automatic void model_calc(input int ch, input int x, output int y, output int s);
        longint acc;
        longint q;
        acc = longint'(mc[ch][0]) * x + longint'(mc[ch][1]) * mx1[ch]
            + longint'(mc[ch][2]) * mx2[ch] + longint'(mc[ch][3]) * my1[ch]
            + longint'(mc[ch][4]) * my2[ch];
        q = floor_div(acc, 2048);
        if (q > 127) begin
            y = 127; s = 1;
        end else if (q < -128) begin
            y = -128; s = 1;
        end else begin
            y = int'(q); s = 0;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_out_data", $signed(out_data), 0);
        check_val("rst_out_ch", out_ch, 0);
        check_val("rst_out_sat", out_sat, 0);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_val("idle_in_ready", in_ready, 1);
    endtask

    task automatic cfg_write(input int ch, input int sel, input int val);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_sel = 3'(sel); cfg_data = 12'(val);
        @(negedge clk);
        cfg_we = 1'b0;
        if (ch < NCH && sel <= 4) mc[ch][sel] = val;
    endtask

    // One sample. wr_k: -1 none, 0 write on the accepting edge, k>=1 write
    // pulse driven k negedges after acceptance. rst_k>=0 aborts with reset.
    // hold: cycles out_ready is held low after out_valid rises.
    task automatic send(input int ch, input int x, input int wr_k, input int wr_ch,
                        input int wr_sel, input int wr_val, input int hold,
                        input int rst_k, output int got_y);
        int  y_exp, s_exp, first, waited;
        bit  good;
        good = (ch < NCH);
        got_y = 0; first = -1; y_exp = 0; s_exp = 0;
        @(negedge clk);
        in_valid = 1'b1; in_ch = 2'(ch); in_data = 12'(x); out_ready = (hold == 0);
        cfg_we = (wr_k == 0); cfg_ch = 2'(wr_ch); cfg_sel = 3'(wr_sel); cfg_data = 12'(wr_val);
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check_val("accept_timeout", 0, 1);
            in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
            return;
        end
        if (good) model_calc(ch, x, y_exp, s_exp);
        if (wr_k >= 0 && wr_ch < NCH && wr_sel <= 4) mc[wr_ch][wr_sel] = wr_val;
        for (int m = 0; m <= 6; m++) begin
            @(negedge clk);
            if (m == 0) in_valid = 1'b0;
            cfg_we = (wr_k >= 1 && m == wr_k);
            if (out_valid && first < 0) first = m;
            if (!good && m == 1) check_val("bad_ch_ready", in_ready, 1);
            if (rst_k >= 0 && m == rst_k) begin
                rst = 1'b0;
            end else if (rst_k >= 0 && m == rst_k + 1) begin
                check_val("abort_out_valid", out_valid, 0);
                check_val("abort_in_ready", in_ready, 0);
                rst = 1'b1; out_ready = 1'b1;
                model_reset();
                @(negedge clk);
                check_val("abort_idle_ready", in_ready, 1);
                return;
            end
        end
        if (!good) begin
            check_val("bad_ch_no_out", first, -1);
            return;
        end
        check_val("latency", first, 6);
        got_y = int'($signed(out_data));
        check_val("out_data", got_y, y_exp);
        check_val("out_ch", out_ch, ch);
        check_val("out_sat", out_sat, s_exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = 1'b1; in_ch = 2'($urandom_range(0, 2)); in_data = 12'($urandom);
            check_val("hold_valid", out_valid, 1);
            check_val("hold_data", $signed(out_data), y_exp);
            check_val("hold_ch", out_ch, ch);
            check_val("hold_in_ready", in_ready, 0);
        end
        if (hold > 0) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
        end
        mx2[ch] = mx1[ch]; mx1[ch] = x;
        my2[ch] = my1[ch]; my1[ch] = y_exp;
    endtask

    initial begin
        int y;
        int ch, x, wr_k, wr_ch, wr_sel, wr_val, hold;
        checks = 0; failures = 0;
        rst = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;

        // 1: impulse on ch0 with default coefficients
        do_reset();
        send(0, 100, -1, 0, 0, 0, 0, -1, y); check_val("s1_y0", y, 1);
        send(0, 0,   -1, 0, 0, 0, 0, -1, y); check_val("s1_y1", y, 2);
        send(0, 0,   -1, 0, 0, 0, 0, -1, y); check_val("s1_y2", y, 2);
        send(0, 0,   -1, 0, 0, 0, 0, -1, y);

        // 2: saturation on ch1
        cfg_write(1, 0, 2047);
        send(1, 2047,  -1, 0, 0, 0, 0, -1, y); check_val("s2_pos", y, 127);
        check_val("s2_pos_sat", out_sat, 1);
        send(1, -2048, -1, 0, 0, 0, 0, -1, y); check_val("s2_neg", y, -128);
        check_val("s2_neg_sat", out_sat, 1);

        // 3: back-pressure with a pending sample offered
        send(2, 50,  -1, 0, 0, 0, 10, -1, y);
        send(2, -30, -1, 0, 0, 0, 0,  -1, y);

        // 4: interleave ch0 impulse with ch1 zeros
        do_reset();
        send(0, 100, -1, 0, 0, 0, 0, -1, y); check_val("s4_c0_0", y, 1);
        send(1, 0,   -1, 0, 0, 0, 0, -1, y); check_val("s4_c1_0", y, 0);
        send(0, 0,   -1, 0, 0, 0, 0, -1, y); check_val("s4_c0_1", y, 2);
        send(1, 0,   -1, 0, 0, 0, 0, -1, y); check_val("s4_c1_1", y, 0);
        send(0, 0,   -1, 0, 0, 0, 0, -1, y); check_val("s4_c0_2", y, 2);

        // 5: write during MAC2, and same-edge write + accept
        do_reset();
        send(0, 100, 2, 0, 0, 0, 0, -1, y);    check_val("s5_old_b0", y, 1);
        send(0, 100, -1, 0, 0, 0, 0, -1, y);   check_val("s5_new_b0", y, 2);
        send(2, 100, 0, 2, 0, 2047, 0, -1, y); check_val("s5_same_edge", y, 1);
        send(2, 100, -1, 0, 0, 0, 0, -1, y);   check_val("s5_after", y, 102);
        cfg_write(3, 0, 5);                    // out-of-range channel: ignored
        cfg_write(0, 6, 5);                    // out-of-range select: ignored
        send(1, 100, -1, 0, 0, 0, 0, -1, y);   check_val("s5_ignored_wr", y, 1);

        // 6: reset during MAC3, then impulse again; invalid channel
        do_reset();
        send(0, 100, -1, 0, 0, 0, 0, 3, y);
        send(0, 100, -1, 0, 0, 0, 0, -1, y); check_val("s6_y0", y, 1);
        send(0, 0,   -1, 0, 0, 0, 0, -1, y); check_val("s6_y1", y, 2);
        send(3, 77,  -1, 0, 0, 0, 0, -1, y);
        send(0, 0,   -1, 0, 0, 0, 0, -1, y); check_val("s6_y2", y, 2);

        // randomized traffic and coefficient writes
        for (int i = 0; i < 60; i++) begin
            ch     = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            x      = int'($urandom_range(0, 4095)) - 2048;
            wr_k   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1;
            wr_ch  = int'($urandom_range(0, 3));
            wr_sel = int'($urandom_range(0, 7));
            wr_val = int'($urandom_range(0, 4095)) - 2048;
            hold   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            send(ch, x, wr_k, wr_ch, wr_sel, wr_val, hold, -1, y);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
